imem_loader: RTL and testbench

Host-side programming engine for the mips32 core's instruction memory: the writer for the instruction bank that `ifetch` only reads. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words into sequential instruction-memory addresses starting at 0, then releases the core to execute. It watches the core's halt indication and returns the core to a stopped, reloadable state.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the mips32 instruction-memory loader: the loader state
// encoding, the decode halt opcode and the default instruction-memory geometry.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte-to-word assembler: the first byte lands in [31:23+1], the
// fourth completes the word and raises word_valid in that same cycle.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] held;

    // NOTE: word_valid and word are combinational so the parent can register the
    // memory write on the same edge that accepts the fourth byte.
    assign word_valid = byte_valid && (cnt == 2'd3);
    assign word       = {held, byte_data};

    // NOTE: sequential state uses non-blocking assignments only; every flop here
    // is also cleared by the asynchronous reset so a partial word never survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            held <= 24'd0;
        end else if (clear) begin
            cnt  <= 2'd0;
            held <= 24'd0;
        end else if (byte_valid) begin
            cnt  <= cnt + 2'd1;
            held <= {held[15:0], byte_data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory programming engine: packs a host byte stream into words,
// writes them from address 0, then runs the core until it halts.
// Optional trailing XOR checksum word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    input  logic              core_hlt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    loader_state_t   state;
    logic [ADDR_W:0] len_q;
    logic            accept;
    logic            start_ok;
    logic            len_bad;
    logic            word_valid;
    logic [31:0]     word;

    assign accept   = in_valid && in_ready;
    assign start_ok = load_start && (state inside {ST_IDLE, ST_HALTED, ST_ERROR});
    assign len_bad  = (load_len == '0) || (load_len > DEPTH);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_acc <= 32'd0;
        end else if (start_ok) begin
            csum_acc <= 32'd0;
        end else if (state == ST_LOAD && word_valid) begin
            csum_acc <= csum_acc ^ word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            core_run     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_HALTED, ST_ERROR: begin
                    if (load_start) begin
                        done         <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= '0;
                        len_q        <= load_len;
                        if (len_bad) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            err      <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= word;
                        words_loaded <= words_loaded + LEN_ONE;
                        if (words_loaded + LEN_ONE == len_q) begin
                            in_ready <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            in_ready <= 1'b1;
                            state    <= ST_CHECK;
`else
                            state    <= ST_RUN;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (word_valid) begin
                        in_ready <= 1'b0;
                        if (word == csum_acc) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    // core_run is released one cycle after entering RUN, which
                    // lines it up one cycle after the final write or checksum.
                    if (core_hlt) begin
                        state    <= ST_HALTED;
                        core_run <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        core_run <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams checked against a
// word-level model of the expected memory writes and control sequencing.
module tb_imem_loader;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];
    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [10:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        core_hlt = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    wr_t wlog[$];

    wire [58:0] outs = {in_ready, imem_we, imem_addr, imem_wdata, core_run,
                        busy, done, err, words_loaded};

    imem_loader #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_len     (load_len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .core_hlt     (core_hlt),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) wlog.push_back('{imem_addr, imem_wdata, cyc});
    end

    // Byte stream for a load: words big-endian, then the XOR checksum (plus a
    // deliberate offset for negative tests) when the checksum feature is built.
    function automatic byte_q_t stream(input word_q_t w, input logic [31:0] csum_delta);
        byte_q_t     b;
        logic [31:0] x;
        x = 32'd0;
        foreach (w[i]) begin
            x = x ^ w[i];
            for (int k = 3; k >= 0; k--) b.push_back(w[i][k*8 +: 8]);
        end
        x = x + csum_delta;
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 3; k >= 0; k--) b.push_back(x[k*8 +: 8]);
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        core_hlt = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_load(input logic [10:0] len);
        load_start = 1'b1;
        load_len = len;
        tick();
        load_start = 1'b0;
    endtask

    // Offers the first n bytes of b; returns right after the edge that takes the
    // last one. Optionally jitters in_valid/core_hlt and collides a load_start.
    task automatic send(input byte_q_t b, input int n, input bit gaps, input bit collide);
        int i = 0;
        int budget = 0;
        bit took;
        while (i < n && budget < 8 * n + 64) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = in_valid ? b[i] : 8'($urandom);
            core_hlt = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            took = in_valid && in_ready;
            load_start = collide && took && (i == n - 1);
            load_len = 11'd5;
            tick();
            budget++;
            if (took) i++;
        end
        in_valid = 1'b0;
        core_hlt = 1'b0;
        load_start = 1'b0;
        n_tests++;
        if (i != n) begin
            n_fail++;
            $display("FAIL send_bytes: consumed %0d bytes, required %0d", i, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_held: outputs %h, required 0", outs);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_released: outputs %h, required 0", outs);
        end
    endtask

    task automatic test_basic();
        word_q_t w = '{32'h01020304, 32'hAABBCCDD};
        wlog.delete();
        start_load(11'd2);
        n_tests++;
        if ({in_ready, busy, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_enter_load: ready/busy/err %b, required 110", {in_ready, busy, err});
        end
        send(stream(w, 32'd0), 4 * w.size() + 4 * `ifdef IMEM_LOADER_CHECKSUM_EN 1 `else 0 `endif, 1'b0, 1'b0);
        n_tests++;
        if ({in_ready, core_run} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_after_last_byte: ready/run %b, required 00", {in_ready, core_run});
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL basic_last_write: we/addr/data %h, required %h",
                     {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd1, 32'hAABBCCDD});
        end
`endif
        tick();
        n_tests++;
        if ({core_run, imem_we, words_loaded} !== {1'b1, 1'b0, 11'd2}) begin
            n_fail++;
            $display("FAIL basic_core_run: run/we/words %h, required %h",
                     {core_run, imem_we, words_loaded}, {1'b1, 1'b0, 11'd2});
        end
        n_tests++;
        if (wlog.size() != 2) begin
            n_fail++;
            $display("FAIL basic_write_count: %0d writes, required 2", wlog.size());
        end else begin
            foreach (w[i]) begin
                n_tests++;
                if (wlog[i].addr !== 10'(i) || wlog[i].data !== w[i]) begin
                    n_fail++;
                    $display("FAIL basic_write[%0d]: %h@%0d, required %h@%0d",
                             i, wlog[i].data, wlog[i].addr, w[i], i);
                end
            end
            n_tests++;
            if (wlog[1].cyc - wlog[0].cyc != 4) begin
                n_fail++;
                $display("FAIL basic_throughput: write spacing %0d, required 4", wlog[1].cyc - wlog[0].cyc);
            end
        end
    endtask

    task automatic test_halt();
        start_load(11'd1);
        n_tests++;
        if ({core_run, done, words_loaded} !== {1'b1, 1'b0, 11'd2}) begin
            n_fail++;
            $display("FAIL halt_start_ignored: run/done/words %h, required %h",
                     {core_run, done, words_loaded}, {1'b1, 1'b0, 11'd2});
        end
        core_hlt = 1'b1;
        tick();
        core_hlt = 1'b0;
        n_tests++;
        if ({core_run, done, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL halt_response: run/done/busy %b, required 010", {core_run, done, busy});
        end
        tick();
        tick();
        n_tests++;
        if ({core_run, done, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL halt_sticky: run/done/busy %b, required 010", {core_run, done, busy});
        end
    endtask

    task automatic test_gaps();
        word_q_t w;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        wlog.delete();
        start_load(11'd3);
        n_tests++;
        if ({done, words_loaded, in_ready} !== {1'b0, 11'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL gaps_reload_clear: done/words/ready %h, required %h",
                     {done, words_loaded, in_ready}, {1'b0, 11'd0, 1'b1});
        end
        send(stream(w, 32'd0), stream(w, 32'd0).size(), 1'b1, 1'b0);
        tick();
        n_tests++;
        if ({core_run, done, words_loaded} !== {1'b1, 1'b0, 11'd3}) begin
            n_fail++;
            $display("FAIL gaps_run: run/done/words %h, required %h",
                     {core_run, done, words_loaded}, {1'b1, 1'b0, 11'd3});
        end
        n_tests++;
        if (wlog.size() != 3) begin
            n_fail++;
            $display("FAIL gaps_write_count: %0d writes, required 3", wlog.size());
        end else begin
            foreach (w[i]) begin
                n_tests++;
                if (wlog[i].addr !== 10'(i) || wlog[i].data !== w[i]) begin
                    n_fail++;
                    $display("FAIL gaps_write[%0d]: %h@%0d, required %h@%0d",
                             i, wlog[i].data, wlog[i].addr, w[i], i);
                end
            end
        end
        core_hlt = 1'b1;
        tick();
        core_hlt = 1'b0;
    endtask

    task automatic test_back_to_back();
        word_q_t w;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        wlog.delete();
        start_load(11'd3);
        send(stream(w, 32'd0), stream(w, 32'd0).size(), 1'b0, 1'b1);
        tick();
        tick();
        n_tests++;
        if ({core_run, in_ready, words_loaded} !== {1'b1, 1'b0, 11'd3}) begin
            n_fail++;
            $display("FAIL b2b_collide_ignored: run/ready/words %h, required %h",
                     {core_run, in_ready, words_loaded}, {1'b1, 1'b0, 11'd3});
        end
        n_tests++;
        if (wlog.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_write_count: %0d writes, required 3", wlog.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_tests++;
                if (wlog[i].cyc - wlog[i-1].cyc != 4 || wlog[i].data !== w[i]) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: %h spacing %0d, required %h spacing 4",
                             i, wlog[i].data, wlog[i].cyc - wlog[i-1].cyc, w[i]);
                end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL b2b_async_reset_in_run: outputs %h, required 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bad_len();
        wlog.delete();
        start_load(11'd0);
        n_tests++;
        if ({err, busy, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL badlen_zero: err/busy/ready %b, required 100", {err, busy, in_ready});
        end
        tick();
        tick();
        start_load(11'd1025);
        n_tests++;
        if ({err, busy, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL badlen_1025: err/busy/ready %b, required 100", {err, busy, in_ready});
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (core_run !== 1'b0 || wlog.size() != 0) begin
            n_fail++;
            $display("FAIL badlen_no_activity: run %b writes %0d, required 0 and 0", core_run, wlog.size());
        end
        start_load(11'd1024);
        n_tests++;
        if ({err, busy, in_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL badlen_1024_accepted: err/busy/ready %b, required 011", {err, busy, in_ready});
        end
        do_reset();
    endtask

    task automatic test_reset_midload();
        word_q_t w;
        word_q_t nw;
        w.push_back($urandom);
        w.push_back($urandom);
        nw.push_back($urandom);
        wlog.delete();
        start_load(11'd2);
        send(stream(w, 32'd0), 6, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs !== 59'd0) begin
            n_fail++;
            $display("FAIL midload_async_reset: outputs %h, required 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (wlog.size() != 1 || wlog[0].addr !== 10'd0 || wlog[0].data !== w[0]) begin
            n_fail++;
            $display("FAIL midload_writes_before_reset: %0d writes, required 1 of %h@0", wlog.size(), w[0]);
        end
        start_load(11'd1);
        send(stream(nw, 32'd0), stream(nw, 32'd0).size(), 1'b0, 1'b0);
        tick();
        n_tests++;
        if (wlog.size() != 2 || wlog[1].addr !== 10'd0 || wlog[1].data !== nw[0] || core_run !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_fresh_reload: %0d writes last %h, run %b, required 2 writes last %h@0, run 1",
                     wlog.size(), wlog[wlog.size()-1].data, core_run, nw[0]);
        end
        do_reset();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        word_q_t w = '{32'h11111111, 32'h22222222};
        byte_q_t b;
        wlog.delete();
        start_load(11'd2);
        send(stream(w, 32'd0), 12, 1'b0, 1'b0);
        tick();
        n_tests++;
        if ({core_run, err, wlog.size() == 2} !== 3'b101) begin
            n_fail++;
            $display("FAIL csum_match: run %b err %b writes %0d, required 1 0 2", core_run, err, wlog.size());
        end
        core_hlt = 1'b1;
        tick();
        core_hlt = 1'b0;
        wlog.delete();
        start_load(11'd2);
        b = stream(w, 32'd1);
        n_tests++;
        if ({b[8], b[9], b[10], b[11]} !== 32'h33333334) begin
            n_fail++;
            $display("FAIL csum_bad_stream: %h, required 33333334", {b[8], b[9], b[10], b[11]});
        end
        send(b, 12, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({core_run, err, busy} !== 3'b010) begin
                n_fail++;
                $display("FAIL csum_mismatch[%0d]: run/err/busy %b, required 010", i, {core_run, err, busy});
            end
            tick();
        end
        n_tests++;
        if (wlog.size() != 2) begin
            n_fail++;
            $display("FAIL csum_not_written: %0d writes, required 2", wlog.size());
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_gaps();
        test_back_to_back();
        test_bad_len();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
